// File: rtl/cpu_types_pkg.sv
// cpu_types_pkg -- shared CPU types for the pipeline control blocks.
//   REG_W          : register-number width (5 for a 32-entry file)
//   regbits_t      : register-number type
//   hazard_state_t : hazard controller state (RUN, DRAIN, HALT)
package cpu_types_pkg;

  localparam int REG_W = 5;

  typedef logic [REG_W-1:0] regbits_t;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    HALT  = 2'd2
  } hazard_state_t;

endpackage

// File: rtl/sat_counter.sv
// sat_counter -- up counter that sticks at all-ones.
// Ports:
//   clk    in   clock, rising edge
//   rst    in   asynchronous active-high reset to zero
//   enable in   count up by one this cycle (ignored once saturated)
//   clear  in   synchronous clear to zero, wins over enable
//   count  out  CNT_W-bit current count
module sat_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             clear,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] count_r;

  // Count register: clear first, then saturating increment.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_r <= {CNT_W{1'b0}};
    end else if (clear) begin
      count_r <= {CNT_W{1'b0}};
    end else if (enable && (count_r != {CNT_W{1'b1}})) begin
      count_r <= count_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      count_r <= count_r;
    end
  end

  assign count = count_r;

endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl -- pipeline hazard / halt controller for a 5-stage CPU.
// Produces PC and pipeline-register write enables and bubble (flush)
// requests for data waits, taken branches, load-use hazards, instruction
// misses and the halt drain sequence. Outputs are combinational from the
// state register and current inputs.
// Ports:
//   CLK, RST                        clock (rising edge), async active-high reset
//   ihit, dhit                      instruction / data access complete
//   memdREN, memdWEN                MEM-stage data read / write request
//   memPCSrc, memHalt               MEM-stage taken branch / halt
//   exdREN, exwsel, idrs, idrt      EX load + destination, ID sources
//   pcW, ifidW, idexW, exmemW, memwbW   write enables
//   ifidFlush, idexFlush, exmemFlush    bubble on next write
//   halt                            processor halted
//   stallCount, flushCount          perf counters (CNT_W bits)
// Configuration macro: HAZARD_PERF_EN -- when defined, stallCount and
// flushCount are live saturating counters; otherwise they are tied to 0.
module hazard_ctrl
  import cpu_types_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             ihit,
  input  logic             dhit,
  input  logic             memdREN,
  input  logic             memdWEN,
  input  logic             memPCSrc,
  input  logic             memHalt,
  input  logic             exdREN,
  input  regbits_t         exwsel,
  input  regbits_t         idrs,
  input  regbits_t         idrt,
  output logic             pcW,
  output logic             ifidW,
  output logic             idexW,
  output logic             exmemW,
  output logic             memwbW,
  output logic             ifidFlush,
  output logic             idexFlush,
  output logic             exmemFlush,
  output logic             halt,
  output logic [CNT_W-1:0] stallCount,
  output logic [CNT_W-1:0] flushCount
);

  hazard_state_t state_r;
  hazard_state_t state_next_s;
  logic          data_wait_s;
  logic          load_use_s;

  // A MEM access that has not completed freezes the whole pipe.
  assign data_wait_s = (memdREN || memdWEN) && !dhit;

  // Register 0 is hardwired, so a load "writing" it can never create a hazard.
  assign load_use_s = exdREN && (exwsel != {REG_W{1'b0}}) &&
                      ((exwsel == idrs) || (exwsel == idrt));

  // State register.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_r <= RUN;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state and output decode, priority order inside RUN.
  always_comb begin
    state_next_s = state_r;
    pcW          = 1'b1;
    ifidW        = 1'b1;
    idexW        = 1'b1;
    exmemW       = 1'b1;
    memwbW       = 1'b1;
    ifidFlush    = 1'b0;
    idexFlush    = 1'b0;
    exmemFlush   = 1'b0;
    halt         = 1'b0;
    case (state_r)
      RUN: begin
        if (memHalt) begin
          // Let the halt retire into WB only, then drain.
          pcW          = 1'b0;
          ifidW        = 1'b0;
          idexW        = 1'b0;
          exmemW       = 1'b0;
          state_next_s = DRAIN;
        end else if (data_wait_s) begin
          pcW    = 1'b0;
          ifidW  = 1'b0;
          idexW  = 1'b0;
          exmemW = 1'b0;
          memwbW = 1'b0;
        end else if (memPCSrc) begin
          // Squash the three younger wrong-path instructions.
          ifidFlush  = 1'b1;
          idexFlush  = 1'b1;
          exmemFlush = 1'b1;
        end else if (load_use_s) begin
          // Hold PC and IF/ID, insert a bubble into EX.
          pcW       = 1'b0;
          ifidW     = 1'b0;
          idexFlush = 1'b1;
        end else if (!ihit) begin
          // Fetch not ready: keep PC, feed a bubble into ID.
          pcW       = 1'b0;
          ifidFlush = 1'b1;
        end else begin
          state_next_s = RUN;
        end
      end
      DRAIN: begin
        pcW          = 1'b0;
        ifidW        = 1'b0;
        idexW        = 1'b0;
        exmemW       = 1'b0;
        memwbW       = 1'b0;
        state_next_s = HALT;
      end
      HALT: begin
        pcW          = 1'b0;
        ifidW        = 1'b0;
        idexW        = 1'b0;
        exmemW       = 1'b0;
        memwbW       = 1'b0;
        halt         = 1'b1;
        state_next_s = HALT;
      end
      default: begin
        pcW          = 1'b0;
        ifidW        = 1'b0;
        idexW        = 1'b0;
        exmemW       = 1'b0;
        memwbW       = 1'b0;
        state_next_s = RUN;
      end
    endcase
  end

`ifdef HAZARD_PERF_EN
  logic stall_en_s;
  logic flush_en_s;

  // Any RUN cycle that holds the PC counts as a stall.
  assign stall_en_s = (state_r == RUN) && !pcW;
  // Branch flush wins only when no halt and no data wait take priority.
  assign flush_en_s = (state_r == RUN) && memPCSrc && !memHalt && !data_wait_s;

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk    (CLK),
    .rst    (RST),
    .enable (stall_en_s),
    .clear  (1'b0),
    .count  (stallCount)
  );

  sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk    (CLK),
    .rst    (RST),
    .enable (flush_en_s),
    .clear  (1'b0),
    .count  (flushCount)
  );
`else
  assign stallCount = {CNT_W{1'b0}};
  assign flushCount = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl -- self-checking bench for hazard_ctrl.
// Each cycle the stimulus driver pushes the expected outputs and counter
// values onto a scoreboard queue; the scenario task pops and compares them
// #1 after driving, half a cycle away from the rising edge.
// Counter expectations follow HAZARD_PERF_EN (saturating counts, else 0).
module tb_hazard_ctrl;

  localparam int CNT_W   = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  // Expected output vector order:
  // {pcW, ifidW, idexW, exmemW, memwbW, ifidFlush, idexFlush, exmemFlush, halt}
  localparam logic [8:0] V_NORM  = 9'b11111_000_0;
  localparam logic [8:0] V_FRZ   = 9'b00000_000_0;
  localparam logic [8:0] V_BR    = 9'b11111_111_0;
  localparam logic [8:0] V_LU    = 9'b00111_010_0;
  localparam logic [8:0] V_IM    = 9'b01111_100_0;
  localparam logic [8:0] V_MH    = 9'b00001_000_0;
  localparam logic [8:0] V_HALT  = 9'b00000_000_1;

  // Control input code: {ihit, dhit, memdREN, memdWEN, memPCSrc, memHalt, exdREN}
  localparam logic [6:0] C_IDLE  = 7'b1100000;
  localparam logic [6:0] C_DRD   = 7'b1010000;
  localparam logic [6:0] C_DWR   = 7'b1001000;
  localparam logic [6:0] C_DHIT  = 7'b1110000;
  localparam logic [6:0] C_BRIM  = 7'b0100100;
  localparam logic [6:0] C_BRDW  = 7'b1010100;
  localparam logic [6:0] C_BRDH  = 7'b1110100;
  localparam logic [6:0] C_BRLU  = 7'b1100101;
  localparam logic [6:0] C_LOAD  = 7'b1100001;
  localparam logic [6:0] C_IMISS = 7'b0100000;
  localparam logic [6:0] C_IMLU  = 7'b0100001;
  localparam logic [6:0] C_MH    = 7'b1100010;
  localparam logic [6:0] C_MHDW  = 7'b1010010;

  typedef struct {
    logic [6:0] c;
    logic [4:0] ws;
    logic [4:0] rs;
    logic [4:0] rt;
    logic [8:0] v;
    bit         st;
    bit         fl;
  } stim_t;

  typedef struct {
    logic [8:0]       v;
    logic [CNT_W-1:0] sc;
    logic [CNT_W-1:0] fc;
  } exp_t;

  logic             CLK = 1'b0;
  logic             RST = 1'b1;
  logic             ihit, dhit, memdREN, memdWEN, memPCSrc, memHalt, exdREN;
  logic [4:0]       exwsel, idrs, idrt;
  logic             pcW, ifidW, idexW, exmemW, memwbW;
  logic             ifidFlush, idexFlush, exmemFlush, halt;
  logic [CNT_W-1:0] stallCount, flushCount;
  logic [8:0]       obs;

  exp_t sb_q[$];
  int   vectors     = 0;
  int   miscompares = 0;
  int   stall_n     = 0;
  int   flush_n     = 0;

  hazard_ctrl #(.CNT_W(CNT_W)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .ihit       (ihit),
    .dhit       (dhit),
    .memdREN    (memdREN),
    .memdWEN    (memdWEN),
    .memPCSrc   (memPCSrc),
    .memHalt    (memHalt),
    .exdREN     (exdREN),
    .exwsel     (exwsel),
    .idrs       (idrs),
    .idrt       (idrt),
    .pcW        (pcW),
    .ifidW      (ifidW),
    .idexW      (idexW),
    .exmemW     (exmemW),
    .memwbW     (memwbW),
    .ifidFlush  (ifidFlush),
    .idexFlush  (idexFlush),
    .exmemFlush (exmemFlush),
    .halt       (halt),
    .stallCount (stallCount),
    .flushCount (flushCount)
  );

  always #5 CLK = ~CLK;

  assign obs = {pcW, ifidW, idexW, exmemW, memwbW, ifidFlush, idexFlush, exmemFlush, halt};

  function automatic logic [CNT_W-1:0] exp_cnt(input int n);
    logic [CNT_W-1:0] r;
    r = CNT_W'((n > CNT_MAX) ? CNT_MAX : n);
`ifndef HAZARD_PERF_EN
    r = '0;
`endif
    return r;
  endfunction

  function automatic stim_t mk(input logic [6:0] c, input logic [4:0] ws, input logic [4:0] rs,
                               input logic [4:0] rt, input logic [8:0] v, input bit st, input bit fl);
    stim_t s;
    s.c = c; s.ws = ws; s.rs = rs; s.rt = rt; s.v = v; s.st = st; s.fl = fl;
    return s;
  endfunction

  // Drive one cycle of inputs and push its expected result.
  task automatic apply(input stim_t s);
    exp_t e;
    {ihit, dhit, memdREN, memdWEN, memPCSrc, memHalt, exdREN} = s.c;
    exwsel = s.ws;
    idrs   = s.rs;
    idrt   = s.rt;
    e.v  = s.v;
    e.sc = exp_cnt(stall_n);
    e.fc = exp_cnt(flush_n);
    sb_q.push_back(e);
    if (s.st) stall_n++;
    if (s.fl) flush_n++;
  endtask

  task automatic test_reset();
    stim_t t[$];
    exp_t  e;
    // Reset held: RUN decode, counters frozen at 0.
    t.push_back(mk(C_DRD,  5'd0, 5'd0, 5'd0, V_FRZ,  1'b0, 1'b0));
    t.push_back(mk(C_IDLE, 5'd0, 5'd0, 5'd0, V_NORM, 1'b0, 1'b0));
    foreach (t[k]) begin
      @(negedge CLK); apply(t[k]); #1;
      e = sb_q.pop_front(); vectors++;
      if ({obs, stallCount, flushCount} !== {e.v, e.sc, e.fc}) begin
        miscompares++;
        $display("FAIL reset[%0d]: got out=%b stall=%0d flush=%0d, want out=%b stall=%0d flush=%0d",
                 k, obs, stallCount, flushCount, e.v, e.sc, e.fc);
      end
    end
    RST = 1'b0;
  endtask

  task automatic test_data_wait();
    stim_t t[$];
    exp_t  e;
    t.push_back(mk(C_DRD,  5'd0, 5'd0, 5'd0, V_FRZ,  1'b1, 1'b0));
    t.push_back(mk(C_DRD,  5'd0, 5'd0, 5'd0, V_FRZ,  1'b1, 1'b0));
    t.push_back(mk(C_DRD,  5'd0, 5'd0, 5'd0, V_FRZ,  1'b1, 1'b0));
    t.push_back(mk(C_DHIT, 5'd0, 5'd0, 5'd0, V_NORM, 1'b0, 1'b0));
    t.push_back(mk(C_DWR,  5'd0, 5'd0, 5'd0, V_FRZ,  1'b1, 1'b0));
    t.push_back(mk(C_IDLE, 5'd0, 5'd0, 5'd0, V_NORM, 1'b0, 1'b0));
    foreach (t[k]) begin
      @(negedge CLK); apply(t[k]); #1;
      e = sb_q.pop_front(); vectors++;
      if ({obs, stallCount, flushCount} !== {e.v, e.sc, e.fc}) begin
        miscompares++;
        $display("FAIL data_wait[%0d]: got out=%b stall=%0d flush=%0d, want out=%b stall=%0d flush=%0d",
                 k, obs, stallCount, flushCount, e.v, e.sc, e.fc);
      end
    end
  endtask

  task automatic test_load_use();
    stim_t t[$];
    exp_t  e;
    t.push_back(mk(C_LOAD, 5'd8,  5'd0,  5'd8, V_LU,   1'b1, 1'b0));
    t.push_back(mk(C_LOAD, 5'd17, 5'd17, 5'd3, V_LU,   1'b1, 1'b0));
    t.push_back(mk(C_LOAD, 5'd0,  5'd0,  5'd0, V_NORM, 1'b0, 1'b0));
    t.push_back(mk(C_LOAD, 5'd8,  5'd3,  5'd4, V_NORM, 1'b0, 1'b0));
    t.push_back(mk(C_IDLE, 5'd8,  5'd8,  5'd8, V_NORM, 1'b0, 1'b0));
    foreach (t[k]) begin
      @(negedge CLK); apply(t[k]); #1;
      e = sb_q.pop_front(); vectors++;
      if ({obs, stallCount, flushCount} !== {e.v, e.sc, e.fc}) begin
        miscompares++;
        $display("FAIL load_use[%0d]: got out=%b stall=%0d flush=%0d, want out=%b stall=%0d flush=%0d",
                 k, obs, stallCount, flushCount, e.v, e.sc, e.fc);
      end
    end
  endtask

  task automatic test_branch_priority();
    stim_t t[$];
    exp_t  e;
    t.push_back(mk(C_BRIM,  5'd0, 5'd0, 5'd0, V_BR,   1'b0, 1'b1));
    t.push_back(mk(C_BRDW,  5'd0, 5'd0, 5'd0, V_FRZ,  1'b1, 1'b0));
    t.push_back(mk(C_BRDH,  5'd0, 5'd0, 5'd0, V_BR,   1'b0, 1'b1));
    t.push_back(mk(C_BRLU,  5'd8, 5'd8, 5'd0, V_BR,   1'b0, 1'b1));
    t.push_back(mk(C_IMISS, 5'd0, 5'd0, 5'd0, V_IM,   1'b1, 1'b0));
    t.push_back(mk(C_IMLU,  5'd9, 5'd1, 5'd9, V_LU,   1'b1, 1'b0));
    t.push_back(mk(C_IDLE,  5'd0, 5'd0, 5'd0, V_NORM, 1'b0, 1'b0));
    foreach (t[k]) begin
      @(negedge CLK); apply(t[k]); #1;
      e = sb_q.pop_front(); vectors++;
      if ({obs, stallCount, flushCount} !== {e.v, e.sc, e.fc}) begin
        miscompares++;
        $display("FAIL branch_prio[%0d]: got out=%b stall=%0d flush=%0d, want out=%b stall=%0d flush=%0d",
                 k, obs, stallCount, flushCount, e.v, e.sc, e.fc);
      end
    end
  endtask

  task automatic test_saturation();
    stim_t t[$];
    exp_t  e;
    for (int i = 0; i < 20; i++) t.push_back(mk(C_IMISS, 5'd0, 5'd0, 5'd0, V_IM, 1'b1, 1'b0));
    for (int i = 0; i < 18; i++) t.push_back(mk(C_BRIM, 5'd0, 5'd0, 5'd0, V_BR, 1'b0, 1'b1));
    t.push_back(mk(C_IDLE, 5'd0, 5'd0, 5'd0, V_NORM, 1'b0, 1'b0));
    foreach (t[k]) begin
      @(negedge CLK); apply(t[k]); #1;
      e = sb_q.pop_front(); vectors++;
      if ({obs, stallCount, flushCount} !== {e.v, e.sc, e.fc}) begin
        miscompares++;
        $display("FAIL saturation[%0d]: got out=%b stall=%0d flush=%0d, want out=%b stall=%0d flush=%0d",
                 k, obs, stallCount, flushCount, e.v, e.sc, e.fc);
      end
    end
  endtask

  task automatic test_reset_mid_wait();
    exp_t e;
    @(negedge CLK); apply(mk(C_DRD, 5'd0, 5'd0, 5'd0, V_FRZ, 1'b1, 1'b0)); #1;
    e = sb_q.pop_front(); vectors++;
    if ({obs, stallCount, flushCount} !== {e.v, e.sc, e.fc}) begin
      miscompares++;
      $display("FAIL rst_wait_pre: got out=%b stall=%0d flush=%0d, want out=%b stall=%0d flush=%0d",
               obs, stallCount, flushCount, e.v, e.sc, e.fc);
    end
    // Asynchronous pulse between clock edges: counters clear at once.
    RST = 1'b1; stall_n = 0; flush_n = 0; #1;
    apply(mk(C_DRD, 5'd0, 5'd0, 5'd0, V_FRZ, 1'b0, 1'b0)); #1;
    e = sb_q.pop_front(); vectors++;
    if ({obs, stallCount, flushCount} !== {e.v, e.sc, e.fc}) begin
      miscompares++;
      $display("FAIL rst_wait_in: got out=%b stall=%0d flush=%0d, want out=%b stall=%0d flush=%0d",
               obs, stallCount, flushCount, e.v, e.sc, e.fc);
    end
    apply(mk(C_IDLE, 5'd0, 5'd0, 5'd0, V_NORM, 1'b0, 1'b0)); #1;
    RST = 1'b0;
    e = sb_q.pop_front(); vectors++;
    if ({obs, stallCount, flushCount} !== {e.v, e.sc, e.fc}) begin
      miscompares++;
      $display("FAIL rst_wait_rel: got out=%b stall=%0d flush=%0d, want out=%b stall=%0d flush=%0d",
               obs, stallCount, flushCount, e.v, e.sc, e.fc);
    end
  endtask

  task automatic test_halt();
    stim_t t[$];
    exp_t  e;
    t.push_back(mk(C_MHDW,  5'd0, 5'd0, 5'd0, V_MH,   1'b1, 1'b0));
    t.push_back(mk(C_IDLE,  5'd0, 5'd0, 5'd0, V_FRZ,  1'b0, 1'b0));
    t.push_back(mk(C_IDLE,  5'd0, 5'd0, 5'd0, V_HALT, 1'b0, 1'b0));
    t.push_back(mk(C_BRIM,  5'd0, 5'd0, 5'd0, V_HALT, 1'b0, 1'b0));
    t.push_back(mk(C_MH,    5'd0, 5'd0, 5'd0, V_HALT, 1'b0, 1'b0));
    foreach (t[k]) begin
      @(negedge CLK); apply(t[k]); #1;
      e = sb_q.pop_front(); vectors++;
      if ({obs, stallCount, flushCount} !== {e.v, e.sc, e.fc}) begin
        miscompares++;
        $display("FAIL halt[%0d]: got out=%b stall=%0d flush=%0d, want out=%b stall=%0d flush=%0d",
                 k, obs, stallCount, flushCount, e.v, e.sc, e.fc);
      end
    end
    // Only reset leaves HALT.
    RST = 1'b1; stall_n = 0; flush_n = 0; #1;
    apply(mk(C_IDLE, 5'd0, 5'd0, 5'd0, V_NORM, 1'b0, 1'b0)); #1;
    RST = 1'b0;
    e = sb_q.pop_front(); vectors++;
    if ({obs, stallCount, flushCount} !== {e.v, e.sc, e.fc}) begin
      miscompares++;
      $display("FAIL halt_rst: got out=%b stall=%0d flush=%0d, want out=%b stall=%0d flush=%0d",
               obs, stallCount, flushCount, e.v, e.sc, e.fc);
    end
  endtask

  task automatic test_reset_in_drain();
    stim_t t[$];
    exp_t  e;
    t.push_back(mk(C_MH,   5'd0, 5'd0, 5'd0, V_MH,  1'b1, 1'b0));
    t.push_back(mk(C_IDLE, 5'd0, 5'd0, 5'd0, V_FRZ, 1'b0, 1'b0));
    foreach (t[k]) begin
      @(negedge CLK); apply(t[k]); #1;
      e = sb_q.pop_front(); vectors++;
      if ({obs, stallCount, flushCount} !== {e.v, e.sc, e.fc}) begin
        miscompares++;
        $display("FAIL drain_rst_pre[%0d]: got out=%b stall=%0d flush=%0d, want out=%b stall=%0d flush=%0d",
                 k, obs, stallCount, flushCount, e.v, e.sc, e.fc);
      end
    end
    RST = 1'b1; stall_n = 0; flush_n = 0; #1;
    apply(mk(C_IDLE, 5'd0, 5'd0, 5'd0, V_NORM, 1'b0, 1'b0)); #1;
    RST = 1'b0;
    e = sb_q.pop_front(); vectors++;
    if ({obs, stallCount, flushCount} !== {e.v, e.sc, e.fc}) begin
      miscompares++;
      $display("FAIL drain_rst_in: got out=%b stall=%0d flush=%0d, want out=%b stall=%0d flush=%0d",
               obs, stallCount, flushCount, e.v, e.sc, e.fc);
    end
    @(negedge CLK); apply(mk(C_IDLE, 5'd0, 5'd0, 5'd0, V_NORM, 1'b0, 1'b0)); #1;
    e = sb_q.pop_front(); vectors++;
    if ({obs, stallCount, flushCount} !== {e.v, e.sc, e.fc}) begin
      miscompares++;
      $display("FAIL drain_rst_post: got out=%b stall=%0d flush=%0d, want out=%b stall=%0d flush=%0d",
               obs, stallCount, flushCount, e.v, e.sc, e.fc);
    end
  endtask

  initial begin
    {ihit, dhit, memdREN, memdWEN, memPCSrc, memHalt, exdREN} = C_IDLE;
    exwsel = 5'd0;
    idrs   = 5'd0;
    idrt   = 5'd0;
    test_reset();
    test_data_wait();
    test_load_use();
    test_branch_priority();
    test_saturation();
    test_reset_mid_wait();
    test_halt();
    test_reset_in_drain();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, vectors=%0d", vectors);
    $fatal(1);
  end

endmodule
